// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port (we3/a3/wd3) between two
//   writeback requesters: requester 0 is the main ALU pipeline and
//   requester 1 is a long-latency unit (load/mul). The winning write is
//   registered and drives the register file one cycle after acceptance.
//   A pending-write scoreboard lets decode stall on RAW hazards against
//   writebacks that are still in flight.
//
// Ports
//   clk, rst                   core clock, synchronous active-high reset
//   wb0_valid_i/ready_o        requester 0 handshake
//   wb0_addr_i/data_i          requester 0 destination and data
//   wb1_valid_i/ready_o        requester 1 handshake
//   wb1_addr_i/data_i          requester 1 destination and data
//   pend_set_i, pend_addr_i    issue stage marks a destination pending
//   rs1_i, rs2_i               decode source registers
//   stall_o                    a decode source is pending
//   pending_o                  scoreboard vector (bit 0 always 0)
//   we3, a3, wd3               registered register-file write port
module regfile_wb_arbiter #(
    parameter int REGISTERS = 32,
    parameter int WIDTH     = 32,
    parameter bit RR        = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb0_valid_i,
    output logic                         wb0_ready_o,
    input  logic [$clog2(REGISTERS)-1:0] wb0_addr_i,
    input  logic [WIDTH-1:0]             wb0_data_i,
    input  logic                         wb1_valid_i,
    output logic                         wb1_ready_o,
    input  logic [$clog2(REGISTERS)-1:0] wb1_addr_i,
    input  logic [WIDTH-1:0]             wb1_data_i,
    input  logic                         pend_set_i,
    input  logic [$clog2(REGISTERS)-1:0] pend_addr_i,
    input  logic [$clog2(REGISTERS)-1:0] rs1_i,
    input  logic [$clog2(REGISTERS)-1:0] rs2_i,
    output logic                         stall_o,
    output logic [REGISTERS-1:0]         pending_o,
    output logic                         we3,
    output logic [$clog2(REGISTERS)-1:0] a3,
    output logic [WIDTH-1:0]             wd3
);

    localparam int AW = $clog2(REGISTERS);

    // last_grant = 1 means requester 1 won most recently, so requester 0
    // wins the next conflict.
    logic                 last_grant;
    logic                 grant0;
    logic                 grant1;
    logic [AW-1:0]        sel_addr;
    logic [WIDTH-1:0]     sel_data;
    logic [REGISTERS-1:0] pending;
    logic [REGISTERS-1:0] pending_nxt;

    // Arbitration: combinational on the valids, nothing granted in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (wb0_valid_i && wb1_valid_i) begin
                if (RR && !last_grant) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = wb0_valid_i;
                grant1 = wb1_valid_i;
            end
        end
    end

    assign wb0_ready_o = grant0;
    assign wb1_ready_o = grant1;
    assign sel_addr    = grant1 ? wb1_addr_i : wb0_addr_i;
    assign sel_data    = grant1 ? wb1_data_i : wb0_data_i;

    // Scoreboard next state: the clear tracks the register-file write
    // currently on we3; a set in the same cycle wins because it marks a
    // newer producer of the same register.
    always_comb begin
        pending_nxt = pending;
        if (we3) begin
            pending_nxt[a3] = 1'b0;
        end
        if (pend_set_i && (pend_addr_i != '0)) begin
            pending_nxt[pend_addr_i] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Write-port register stage: accepted transfer appears on we3/a3/wd3
    // in the following cycle. A write to x0 is accepted but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3        <= 1'b0;
            a3         <= '0;
            wd3        <= '0;
            last_grant <= 1'b1;
            pending    <= '0;
        end else begin
            pending <= pending_nxt;
            if (grant0 || grant1) begin
                we3        <= (sel_addr != '0);
                a3         <= sel_addr;
                wd3        <= sel_data;
                last_grant <= grant1;
            end else begin
                we3 <= 1'b0;
            end
        end
    end

    assign pending_o = pending;
    assign stall_o   = ((rs1_i != '0) && pending[rs1_i]) ||
                       ((rs2_i != '0) && pending[rs2_i]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, pend_set;
    logic [4:0]  a0, a1, pend_addr, rs1, rs2;
    logic [31:0] d0, d1;

    logic        r0, r1, stall_o, we3;
    logic [31:0] pending_o;
    logic [4:0]  a3;
    logic [31:0] wd3;

    logic        fp_r0, fp_r1, fp_stall, fp_we3;
    logic [31:0] fp_pending;
    logic [4:0]  fp_a3;
    logic [31:0] fp_wd3;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.REGISTERS(32), .WIDTH(32), .RR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid_i(v0), .wb0_ready_o(r0), .wb0_addr_i(a0), .wb0_data_i(d0),
        .wb1_valid_i(v1), .wb1_ready_o(r1), .wb1_addr_i(a1), .wb1_data_i(d1),
        .pend_set_i(pend_set), .pend_addr_i(pend_addr),
        .rs1_i(rs1), .rs2_i(rs2), .stall_o(stall_o), .pending_o(pending_o),
        .we3(we3), .a3(a3), .wd3(wd3)
    );

    regfile_wb_arbiter #(.REGISTERS(32), .WIDTH(32), .RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .wb0_valid_i(v0), .wb0_ready_o(fp_r0), .wb0_addr_i(a0), .wb0_data_i(d0),
        .wb1_valid_i(v1), .wb1_ready_o(fp_r1), .wb1_addr_i(a1), .wb1_data_i(d1),
        .pend_set_i(pend_set), .pend_addr_i(pend_addr),
        .rs1_i(rs1), .rs2_i(rs2), .stall_o(fp_stall), .pending_o(fp_pending),
        .we3(fp_we3), .a3(fp_a3), .wd3(fp_wd3)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    bit mon_on   = 1'b0;

    // reference model state
    logic        m_last = 1'b1;
    logic [31:0] m_pend = '0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_a    = '0;
    logic        g0_m, g1_m, r0_s, r1_s;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic cyc();
        logic [31:0] nxt;
        logic        m_stall;
        logic [4:0]  ga;
        logic [31:0] gd;
        @(negedge clk);
        g0_m = 1'b0;
        g1_m = 1'b0;
        if (!rst) begin
            if (v0 && v1) begin
                if (!m_last) g1_m = 1'b1;
                else         g0_m = 1'b1;
            end else begin
                g0_m = v0;
                g1_m = v1;
            end
        end
        r0_s = r0;
        r1_s = r1;
        m_stall = ((rs1 != 0) && m_pend[rs1]) || ((rs2 != 0) && m_pend[rs2]);
        chk("ready0", r0_s, g0_m);
        chk("ready1", r1_s, g1_m);
        chk("fp_ready0", fp_r0, !rst && v0);
        chk("fp_ready1", fp_r1, !rst && v1 && !v0);
        chk("pending", pending_o, m_pend);
        chk("stall", stall_o, m_stall);
        ga = g1_m ? a1 : a0;
        gd = g1_m ? d1 : d0;
        nxt = m_pend;
        if (m_we) nxt[m_a] = 1'b0;
        if (pend_set && pend_addr != 0) nxt[pend_addr] = 1'b1;
        if ((g0_m || g1_m) && ga != 0) sbq.push_back('{cyc_cnt + 1, ga, gd});
        @(posedge clk);
        if (rst) begin
            m_pend = '0;
            m_last = 1'b1;
            m_we   = 1'b0;
            m_a    = '0;
        end else begin
            m_pend = nxt;
            m_we   = (g0_m || g1_m) && (ga != 0);
            if (g0_m || g1_m) begin
                m_a    = ga;
                m_last = g1_m;
            end
        end
        cyc_cnt++;
        #1;
    endtask

    // Write-port monitor: each we3 pulse must match the scoreboard front.
    always @(negedge clk) begin
        if (mon_on) begin
            logic exp_w;
            exp_w = (sbq.size() > 0) && (sbq[0].cyc == cyc_cnt);
            chk("we3", we3, exp_w);
            if (exp_w) begin
                chk("a3", a3, sbq[0].a);
                chk("wd3", wd3, sbq[0].d);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        int i0, i1;
        rst = 1'b1;
        v0 = 0; v1 = 0; pend_set = 0;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0; pend_addr = 0; rs1 = 0; rs2 = 0;
        mon_on = 1'b1;

        // reset then idle
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_we3", we3, 0);
        chk("rst_a3", a3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_pending", pending_o, 0);
        cyc();
        cyc();

        // conflict, round-robin order 0,1,0,1 from reset
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 8 && (i0 < 2 || i1 < 2); k++) begin
            v0 = (i0 < 2);
            a0 = (i0 == 0) ? 5'd1 : 5'd2;
            d0 = 32'h1111 * a0;
            v1 = (i1 < 2);
            a1 = (i1 == 0) ? 5'd3 : 5'd4;
            d1 = 32'h1111 * a1;
            cyc();
            if (k < 4) chk($sformatf("rr_order%0d", k), r1_s, k % 2);
            if (g0_m) i0++;
            if (g1_m) i1++;
        end
        v0 = 0; v1 = 0;
        cyc();

        // single write
        v0 = 1; a0 = 5; d0 = 32'hDEADBEEF;
        cyc();
        chk("single_ready", r0_s, 1);
        chk("single_we3", we3, 1);
        chk("single_a3", a3, 5);
        chk("single_wd3", wd3, 32'hDEADBEEF);
        v0 = 0;
        cyc();
        chk("single_we3_off", we3, 0);
        chk("hold_a3", a3, 5);

        // x0 write by requester 1, then a conflict must favour requester 0
        v1 = 1; a1 = 0; d1 = 32'h1234;
        cyc();
        chk("x0_ready", r1_s, 1);
        chk("x0_we3", we3, 0);
        v0 = 1; a0 = 6; d0 = 32'h66;
        a1 = 8; d1 = 32'h88;
        cyc();
        chk("x0_last_grant", r0_s, 1);
        v0 = 0;
        cyc();
        v1 = 0;
        cyc();

        // scoreboard set, stall, clear
        pend_set = 1; pend_addr = 7; rs1 = 7; rs2 = 0;
        cyc();
        pend_set = 0;
        chk("pend7_set", pending_o[7], 1);
        chk("stall_set", stall_o, 1);
        cyc();
        v0 = 1; a0 = 7; d0 = 32'h77;
        cyc();
        v0 = 0;
        chk("stall_during_we", stall_o, 1);
        cyc();
        chk("stall_cleared", stall_o, 0);
        chk("pend7_clear", pending_o[7], 0);

        // x0 set ignored, rs2 path
        pend_set = 1; pend_addr = 0; rs1 = 0; rs2 = 0;
        cyc();
        chk("pend0_ignored", pending_o, 0);
        pend_addr = 7; rs2 = 7;
        cyc();
        pend_set = 0;
        chk("stall_rs2", stall_o, 1);

        // set and clear of reg 7 in the same cycle: set wins
        v0 = 1; a0 = 7; d0 = 32'h700;
        cyc();
        v0 = 0;
        pend_set = 1; pend_addr = 7;
        cyc();
        pend_set = 0;
        chk("set_wins", pending_o[7], 1);
        v0 = 1; a0 = 7; d0 = 32'h701;
        cyc();
        v0 = 0;
        cyc();
        chk("pend7_final", pending_o[7], 0);
        rs1 = 0; rs2 = 0;

        // reset mid-operation
        pend_set = 1; pend_addr = 3;
        cyc();
        pend_set = 0;
        v0 = 1; a0 = 9; d0 = 32'h99;
        cyc();
        v0 = 0;
        rst = 1;
        cyc();
        rst = 0;
        chk("midrst_we3", we3, 0);
        chk("midrst_pending", pending_o, 0);
        v0 = 1; a0 = 10; d0 = 32'hA0;
        v1 = 1; a1 = 11; d1 = 32'hB0;
        cyc();
        chk("midrst_conflict0", r0_s, 1);
        v0 = 0;
        cyc();
        v1 = 0;
        cyc();
        cyc();

        chk("sb_empty", sbq.size(), 0);
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
